// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode values, instruction
// field positions and the fetch/sequence FSM state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_JZ    = 4'b1001;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  localparam int INSTR_W = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPD_MSB = 3;
  localparam int OPD_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4,
    ST_FAULT   = 3'd5
  } fsm_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, load has priority over increment,
// increment wraps modulo 2^PC_W.
module pc_reg #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            ld,
  input  logic [PC_W-1:0] ld_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)      pc <= '0;
    else if (ld)  pc <= ld_val;
    else if (inc) pc <= pc + 1'b1;
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequence stage: fetches instructions, resolves JMP/JZ/NOP/HLT locally
// and hands other opcodes to the control unit for one EXECUTE cycle.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               zero_flag,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic               exec_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               fault
);

  fsm_state_t         state;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         ir_opc;
  logic               pc_inc;
  logic               pc_ld;
  logic [PC_W-1:0]    pc_q;
  logic               timeout_hit;

  assign ir_opc = ir[OPC_MSB:OPC_LSB];
  assign pc_inc = (state == ST_FETCH) && imem_ack;
  assign pc_ld  = (state == ST_DECODE) &&
                  ((ir_opc == OP_JMP) || ((ir_opc == OP_JZ) && zero_flag));

  pc_reg #(.PC_W(PC_W)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc),
    .ld     (pc_ld),
    .ld_val (PC_W'(ir[OPD_MSB:OPD_LSB])),
    .pc     (pc_q)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign operand   = ir[OPD_MSB:OPD_LSB];

`ifdef FETCH_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0] wcnt;

  // Counts unacknowledged FETCH cycles; zero whenever we are outside FETCH.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_FETCH)) wcnt <= '0;
    else if (!imem_ack && !timeout_hit) wcnt <= wcnt + 1'b1;
  end

  assign timeout_hit = (wcnt == WCNT_W'(TIMEOUT - 1));
  assign fault       = (state == ST_FAULT);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign fault          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ir         <= '0;
      imem_req   <= 1'b0;
      opcode     <= 4'b0000;
      exec_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      opcode     <= 4'b0000;
      exec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            state    <= ST_DECODE;
            imem_req <= 1'b0;
          end else if (timeout_hit) begin
            state    <= ST_FAULT;
            imem_req <= 1'b0;
          end
        end
        ST_DECODE: begin
          // Control-flow opcodes finish here and never reach the control unit.
          case (ir_opc)
            OP_JMP, OP_JZ, OP_NOP: begin
              state    <= ST_FETCH;
              imem_req <= 1'b1;
            end
            OP_HLT: begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
            default: begin
              state      <= ST_EXECUTE;
              opcode     <= ir_opc;
              exec_valid <= 1'b1;
            end
          endcase
        end
        ST_EXECUTE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed vector table, hand-written corner cases
// and random programs checked cycle by cycle against an instruction-level model.
module tb_instr_fetch_seq;

  localparam int PC_W    = 4;
  localparam int TIMEOUT = 15;
  localparam int MEMN    = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst, start, zero_flag;
  logic            imem_req, imem_ack;
  logic [PC_W-1:0] imem_addr, pc;
  logic [7:0]      imem_rdata;
  logic [3:0]      opcode, operand;
  logic            exec_valid, halted, fault;

  always #5 clk = ~clk;

  instr_fetch_seq #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .zero_flag  (zero_flag),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .opcode     (opcode),
    .operand    (operand),
    .exec_valid (exec_valid),
    .pc         (pc),
    .halted     (halted),
    .fault      (fault)
  );

  typedef struct packed {
    logic            req;
    logic [PC_W-1:0] addr;
    logic            ev;
    logic [3:0]      op;
    logic [3:0]      opd;
    logic [PC_W-1:0] pcv;
    logic            halt;
    logic            flt;
  } obs_t;

  typedef struct {
    string      nm;
    logic [7:0] ins;
    logic       zf;
    logic       req;
    logic [3:0] addr;
    logic       ev;
    logic [3:0] op;
    logic       halt;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  logic [7:0] mem [MEMN];
  int   dly [256];
  logic zfs [256];
  int   fi, wcnt, nexec;
  bit   junk, rstart;
  obs_t exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic req, input int addr, input logic ev,
                              input logic [3:0] op, input logic [3:0] opd,
                              input logic halt);
    obs_t o;
    o.req = req; o.addr = PC_W'(addr); o.ev = ev; o.op = op; o.opd = opd;
    o.pcv = PC_W'(addr); o.halt = halt; o.flt = 1'b0;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.req = imem_req; o.addr = imem_addr; o.ev = exec_valid; o.op = opcode;
    o.opd = operand; o.pcv = pc; o.halt = halted; o.flt = fault;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < MEMN; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin dly[i] = 0; zfs[i] = 1'b0; end
    junk = 1'b0; rstart = 1'b0;
  endtask

  // Memory responder and datapath stand-in, evaluated once per cycle at negedge.
  task automatic drive();
    if (exec_valid) nexec++;
    zero_flag = zfs[nexec % 256];
    start     = rstart ? 1'($urandom_range(0, 1)) : 1'b0;
    if (imem_req) begin
      if (wcnt >= dly[fi % 256]) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        fi++;
        wcnt = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom);
        wcnt++;
      end
    end else begin
      imem_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00;
    zero_flag = zfs[0];
    fi = 0; wcnt = 0; nexec = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Instruction-level model: expands each instruction into its cycle costs.
  task automatic build_exp(input int limit);
    int p, f, ne;
    logic [3:0] lop;
    logic [7:0] ins;
    p = 0; f = 0; ne = 0; lop = 4'h0;
    exp_q.delete();
    while (exp_q.size() < limit) begin
      for (int w = 0; w <= dly[f % 256]; w++) exp_q.push_back(mk(1'b1, p, 1'b0, 4'h0, lop, 1'b0));
      ins = mem[p]; f++; p = (p + 1) % MEMN; lop = ins[3:0];
      exp_q.push_back(mk(1'b0, p, 1'b0, 4'h0, lop, 1'b0));
      case (ins[7:4])
        4'h8: p = int'(ins[3:0]);
        4'h9: if (zfs[ne % 256]) p = int'(ins[3:0]);
        4'h0: ;
        4'hF: while (exp_q.size() < limit) exp_q.push_back(mk(1'b0, p, 1'b0, 4'h0, lop, 1'b1));
        default: begin
          exp_q.push_back(mk(1'b0, p, 1'b1, ins[7:4], lop, 1'b0));
          ne++;
        end
      endcase
    end
  endtask

  task automatic run_model(input string nm, input int limit);
    build_exp(limit);
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      chk($sformatf("%s cyc%0d", nm, i), 64'(sample()), 64'(exp_q[i]));
      drive();
      tick();
    end
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{"jmp_8A",   8'h8A, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0};
    vecs[1] = '{"jz_nt",    8'h95, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0};
    vecs[2] = '{"jz_taken", 8'h95, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0};
    vecs[3] = '{"nop",      8'h00, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{"load",     8'h13, 1'b0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b0};
    vecs[5] = '{"add",      8'h3F, 1'b0, 1'b0, 4'h1, 1'b1, 4'h3, 1'b0};
    vecs[6] = '{"not",      8'h7E, 1'b1, 1'b0, 4'h1, 1'b1, 4'h7, 1'b0};
    vecs[7] = '{"unused_A", 8'hA5, 1'b0, 1'b0, 4'h1, 1'b1, 4'hA, 1'b0};
    vecs[8] = '{"unused_E", 8'hE1, 1'b0, 1'b0, 4'h1, 1'b1, 4'hE, 1'b0};
    vecs[9] = '{"hlt",      8'hF0, 1'b0, 1'b0, 4'h1, 1'b0, 4'h0, 1'b1};

    clear_cfg();
    do_reset();
    chk("reset_state", 64'(sample()), 64'(obs_t'(0)));

    // Single-instruction table: check the third cycle after start.
    for (int v = 0; v < 10; v++) begin
      clear_cfg();
      mem[0] = vecs[v].ins;
      zfs[0] = vecs[v].zf;
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      drive(); tick();
      drive(); tick();
      chk(vecs[v].nm, {imem_req, imem_addr, exec_valid, opcode, halted},
          {vecs[v].req, vecs[v].addr, vecs[v].ev, vecs[v].op, vecs[v].halt});
    end

    // Reset while FETCH sees an ack: no IR update, everything back to zero.
    clear_cfg();
    mem[0] = 8'h5C; dly[0] = 10;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    drive(); tick();
    chk("mid_fetch_req", 64'(imem_req), 64'(1));
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 8'hC7;
    tick();
    chk("rst_mid_fetch", 64'(sample()), 64'(obs_t'(0)));
    rst = 1'b0; imem_ack = 1'b0;
    tick();
    chk("idle_after_rst", 64'(sample()), 64'(obs_t'(0)));

    // Short program ending in HLT; start afterwards must be ignored.
    clear_cfg();
    mem[0] = 8'h13; mem[1] = 8'h35; mem[2] = 8'hF0;
    run_model("prog", 14);
    chk("prog_halt", {halted, pc, imem_req}, {1'b1, 4'h3, 1'b0});
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("halt_sticky", {halted, imem_req, exec_valid}, {1'b1, 1'b0, 1'b0});

    clear_cfg();
    mem[0] = 8'h13; dly[0] = 4;
    run_model("ack_delay4", 12);

    clear_cfg();
    mem[0] = 8'h8F; mem[15] = 8'h31;
    run_model("pc_wrap", 20);

    clear_cfg();
    mem[0] = 8'h42; dly[0] = TIMEOUT - 1;
    run_model("ack_last_cycle", TIMEOUT + 6);

    // Ack never arrives.
    clear_cfg();
    dly[0] = 100000;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < TIMEOUT; c++) begin drive(); tick(); end
    chk("wait_cycle15", {fault, imem_req}, {1'b0, 1'b1});
    drive(); tick();
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_fault", {fault, imem_req}, {1'b1, 1'b0});
    drive(); drive(); tick();
    chk("fault_sticky", {fault, imem_req, exec_valid}, {1'b1, 1'b0, 1'b0});
`else
    chk("no_timeout", {fault, imem_req}, {1'b0, 1'b1});
    for (int c = 0; c < 20; c++) begin drive(); tick(); end
    chk("still_waiting", {fault, imem_req, imem_addr}, {1'b0, 1'b1, 4'h0});
`endif

    // Random programs, random ack latency, stray acks and start outside FETCH.
    for (int r = 0; r < 25; r++) begin
      clear_cfg();
      for (int i = 0; i < MEMN; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) begin
        dly[i] = $urandom_range(0, 3);
        zfs[i] = 1'($urandom_range(0, 1));
      end
      junk = 1'b1; rstart = 1'b1;
      run_model($sformatf("rand%0d", r), 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
